// File: rtl/noc_rr_arb_lock.sv
// Per-output-port round-robin arbiter with wormhole lock.
// Holds a grant from head to tail flit, with an optional stall timeout.
module noc_rr_arb_lock #(
    parameter int NUM_REQ  = 5,
    parameter int MAX_HOLD = 0,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] tail_i,
    input  logic               xfer_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o,
    output logic               timeout_o
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tout_q, tout_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   nxt_ptr;
    logic               tail_rel;
    logic               to_rel;
    logic               rel;

    // Scan downward so the lowest rotated offset from ptr wins.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            j = int'(ptr_q) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_i[IDX_W'(j)]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        int nx;
        nx      = int'(idx_q) + 1;
        nxt_ptr = IDX_W'((nx >= NUM_REQ) ? 0 : nx);
    end

    assign tail_rel = xfer_i && tail_i[idx_q];
    assign to_rel   = (MAX_HOLD != 0) && !xfer_i && (cnt_q == HOLD_LAST);
    assign rel      = tail_rel || to_rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && pick_vld) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (rel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        idx_d  = idx_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        tout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i && pick_vld) begin
                    gnt_d = NUM_REQ'(1) << pick_idx;
                    idx_d = pick_idx;
                end
            end
            LOCKED: begin
                if (rel) begin
                    gnt_d  = '0;
                    ptr_d  = nxt_ptr;
                    cnt_d  = '0;
                    tout_d = to_rel && !tail_rel;
                end else if (xfer_i || MAX_HOLD == 0) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == LOCKED);
    assign timeout_o   = tout_q;

endmodule

// File: tb/tb_noc_rr_arb_lock.sv
// Randomized check of noc_rr_arb_lock against a behavioural arbiter model.
// Three instances: (5 ports, no timeout), (5 ports, hold 4), (1 port, hold 2).
module tb_noc_rr_arb_lock;

    logic       clk = 1'b0;
    logic       rst, en, xfer;
    logic [4:0] req, tail;

    logic [4:0] g0, g1;
    logic [2:0] i0, i1;
    logic       v0, v1, t0, t1;
    logic [0:0] g2, i2;
    logic       v2, t2;

    always #5 clk = ~clk;

    noc_rr_arb_lock #(.NUM_REQ(5), .MAX_HOLD(0)) u0 (
        .clk(clk), .rst(rst), .en_i(en), .req_i(req), .tail_i(tail),
        .xfer_i(xfer), .gnt_o(g0), .gnt_idx_o(i0), .gnt_valid_o(v0),
        .timeout_o(t0)
    );

    noc_rr_arb_lock #(.NUM_REQ(5), .MAX_HOLD(4)) u1 (
        .clk(clk), .rst(rst), .en_i(en), .req_i(req), .tail_i(tail),
        .xfer_i(xfer), .gnt_o(g1), .gnt_idx_o(i1), .gnt_valid_o(v1),
        .timeout_o(t1)
    );

    noc_rr_arb_lock #(.NUM_REQ(1), .MAX_HOLD(2)) u2 (
        .clk(clk), .rst(rst), .en_i(en), .req_i(req[0:0]),
        .tail_i(tail[0:0]), .xfer_i(xfer), .gnt_o(g2), .gnt_idx_o(i2),
        .gnt_valid_o(v2), .timeout_o(t2)
    );

    int total = 0;
    int bad   = 0;

    int NR[3] = '{5, 5, 1};
    int MH[3] = '{0, 4, 2};

    // Model: owner = input holding the output (-1 when free),
    // prio = first input to consider next, stall = cycles without a flit.
    int owner[3];
    int last[3];
    int prio[3];
    int stall[3];
    bit tout[3];
    bit mvalid = 1'b0;

    logic [31:0] ag[3], ai[3];
    logic        av[3], at[3];

    always_comb begin
        ag[0] = {27'b0, g0};
        ag[1] = {27'b0, g1};
        ag[2] = {31'b0, g2};
        ai[0] = {29'b0, i0};
        ai[1] = {29'b0, i1};
        ai[2] = {31'b0, i2};
        av[0] = v0;
        av[1] = v1;
        av[2] = v2;
        at[0] = t0;
        at[1] = t1;
        at[2] = t2;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_gnt(input int m);
        return (owner[m] >= 0) ? (32'(1) << owner[m]) : 32'(0);
    endfunction

    task automatic free_port(input int m);
        prio[m]  = (owner[m] + 1) % NR[m];
        owner[m] = -1;
        stall[m] = 0;
    endtask

    task automatic model_step(input int m);
        int c;
        if (rst) begin
            owner[m] = -1;
            last[m]  = 0;
            prio[m]  = 0;
            stall[m] = 0;
            tout[m]  = 1'b0;
            return;
        end
        tout[m] = 1'b0;
        if (owner[m] < 0) begin
            if (en) begin
                for (int k = 0; k < NR[m]; k++) begin
                    c = (prio[m] + k) % NR[m];
                    if (req[c]) begin
                        owner[m] = c;
                        last[m]  = c;
                        stall[m] = 0;
                        break;
                    end
                end
            end
        end else if (xfer && tail[owner[m]]) begin
            free_port(m);
        end else if (xfer) begin
            stall[m] = 0;
        end else begin
            stall[m]++;
            if (MH[m] != 0 && stall[m] == MH[m]) begin
                tout[m] = 1'b1;
                free_port(m);
            end
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) begin
            model_step(m);
        end
        if (rst) begin
            mvalid = 1'b1;
        end
    end

    task automatic cmp(input int m);
        chk($sformatf("u%0d.gnt", m), ag[m], exp_gnt(m));
        chk($sformatf("u%0d.idx", m), ai[m], 32'(last[m]));
        chk($sformatf("u%0d.valid", m), 32'(av[m]), 32'(owner[m] >= 0));
        chk($sformatf("u%0d.tout", m), 32'(at[m]), 32'(tout[m]));
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            for (int m = 0; m < 3; m++) begin
                cmp(m);
            end
        end
    end

    // Hand-derived expectations checked against both the DUT and the model.
    task automatic lit(input string nm, input int m, input int g,
                       input int i, input bit v, input bit t);
        string p;
        p = $sformatf("%s.u%0d", nm, m);
        chk({p, ".dut.gnt"}, ag[m], 32'(g));
        chk({p, ".dut.idx"}, ai[m], 32'(i));
        chk({p, ".dut.valid"}, 32'(av[m]), 32'(v));
        chk({p, ".dut.tout"}, 32'(at[m]), 32'(t));
        chk({p, ".mdl.gnt"}, exp_gnt(m), 32'(g));
        chk({p, ".mdl.idx"}, 32'(last[m]), 32'(i));
        chk({p, ".mdl.valid"}, 32'(owner[m] >= 0), 32'(v));
        chk({p, ".mdl.tout"}, 32'(tout[m]), 32'(t));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int seg;
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        tail = '0;
        xfer = 1'b0;
        repeat (2) step();
        for (int m = 0; m < 3; m++) begin
            lit("reset", m, 0, 0, 0, 0);
        end

        // first grant from pointer 0 lands on input 2
        rst = 1'b0;
        en  = 1'b1;
        req = 5'b10100;
        step();
        lit("t1", 0, 5'b00100, 2, 1, 0);
        lit("t1", 1, 5'b00100, 2, 1, 0);

        // body flits keep the lock, tail releases, then rotate to 4
        xfer = 1'b1;
        repeat (3) begin
            step();
            lit("t2body", 0, 5'b00100, 2, 1, 0);
        end
        tail = 5'b00100;
        step();
        lit("t2rel", 0, 0, 2, 0, 0);
        lit("t2rel", 1, 0, 2, 0, 0);
        xfer = 1'b0;
        tail = '0;
        step();
        lit("t2next", 0, 5'b10000, 4, 1, 0);

        // release from 4 wraps the pointer to 0
        xfer = 1'b1;
        tail = 5'b10000;
        req  = 5'b10001;
        step();
        lit("t3rel", 0, 0, 4, 0, 0);
        xfer = 1'b0;
        tail = '0;
        step();
        lit("t3wrap", 0, 5'b00001, 0, 1, 0);
        lit("t3wrap", 1, 5'b00001, 0, 1, 0);

        // four stalled cycles trip the hold-4 instance only
        req = '0;
        repeat (3) step();
        lit("t4stall", 1, 5'b00001, 0, 1, 0);
        step();
        lit("t4tout", 1, 0, 0, 0, 1);
        lit("t4nolim", 0, 5'b00001, 0, 1, 0);
        step();
        lit("t4after", 1, 0, 0, 0, 0);
        xfer = 1'b1;
        tail = 5'b00001;
        step();
        lit("t4rel", 0, 0, 0, 0, 0);
        xfer = 1'b0;
        tail = '0;
        req  = 5'b00011;
        step();
        lit("t4ptr", 0, 5'b00010, 1, 1, 0);
        lit("t4ptr", 1, 5'b00010, 1, 1, 0);

        // tail of a non-granted port is ignored; en low blocks arbitration
        xfer = 1'b1;
        tail = 5'b00100;
        step();
        lit("t5other", 0, 5'b00010, 1, 1, 0);
        tail = 5'b00010;
        step();
        lit("t5rel", 0, 0, 1, 0, 0);
        xfer = 1'b0;
        tail = '0;
        en   = 1'b0;
        req  = 5'b11111;
        repeat (2) begin
            step();
            lit("t5en0", 0, 0, 1, 0, 0);
        end

        // reset mid-packet, then arbitration restarts from 0
        en = 1'b1;
        step();
        lit("t6lock", 0, 5'b00100, 2, 1, 0);
        xfer = 1'b1;
        step();
        rst = 1'b1;
        step();
        lit("t6rst", 0, 0, 0, 0, 0);
        lit("t6rst", 1, 0, 0, 0, 0);
        rst  = 1'b0;
        xfer = 1'b0;
        step();
        lit("t6restart", 0, 5'b00001, 0, 1, 0);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            seg  = (cyc / 500) % 3;
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 3) != 0);
            req  = 5'($urandom);
            tail = 5'($urandom & $urandom);
            xfer = ($urandom_range(0, 9) < 3 + 3 * seg);
            step();
        end

        rst = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
